// File: rtl/mc_pkg.sv
// Shared constants for the multicycle control FSM: state codes, opcodes and datapath select encodings.
package mc_pkg;

  localparam int unsigned STATE_W = 7;
  localparam int unsigned OP_W    = 6;

  // Control state codes; anything from 12 upward is unused and recovers to FETCH
  localparam logic [STATE_W-1:0] S_FETCH     = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE    = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEM_ADDR  = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEM_RD    = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEM_WB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEM_WR    = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_R_EXEC    = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_R_WB      = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_BEQ       = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_JUMP      = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_ADDI_EXEC = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_ADDI_WB   = STATE_W'(11);

  // Instruction opcodes (IR[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'h08);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'd0,
    PC_SRC_ALUOUT = 2'd1,
    PC_SRC_JUMP   = 2'd2
  } pc_src_e;

  typedef enum logic [1:0] {
    ALUB_B       = 2'd0,
    ALUB_FOUR    = 2'd1,
    ALUB_IMM     = 2'd2,
    ALUB_IMM_SH2 = 2'd3
  } alu_src_b_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_e;

endpackage

// File: rtl/multicycle_ctrl_state_reg.sv
// Control state register: loads every cycle, clears to FETCH on synchronous active-low reset.
module multicycle_ctrl_state_reg
  import mc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] state_d,
  output logic [STATE_W-1:0] state_q
);

  // State flop with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle datapath: next-state logic and control decode.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_load,
  output logic [1:0]         pc_src,
  output logic               ir_load,
  output logic               mdr_load,
  output logic               ab_load,
  output logic               aluout_load,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [STATE_W-1:0] state,
  output logic               instr_done,
  output logic               illegal_op
);

  logic [STATE_W-1:0] state_d;
  logic [STATE_W-1:0] state_q;

  multicycle_ctrl_state_reg u_state_reg (
    .clk     (clk),
    .reset   (reset),
    .state_d (state_d),
    .state_q (state_q)
  );

  // Debug view of the state reads FETCH while reset is held
  assign state = reset ? state_q : S_FETCH;

  // Next-state selection; memory states hold until mem_ready
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:    state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:    state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  // Control decode from state; everything stays low while reset is held
  always_comb begin
    pc_load     = 1'b0;
    pc_src      = PC_SRC_ALU;
    ir_load     = 1'b0;
    mdr_load    = 1'b0;
    ab_load     = 1'b0;
    aluout_load = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = ALUB_B;
    alu_op      = ALU_ADD;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = ALUB_FOUR;
          ir_load   = mem_ready;
          pc_load   = mem_ready;
        end
        S_DECODE: begin
          ab_load     = 1'b1;
          aluout_load = 1'b1;
          alu_src_b   = ALUB_IMM_SH2;
          case (opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
            default:                                       illegal_op = 1'b1;
          endcase
        end
        S_MEM_ADDR, S_ADDI_EXEC: begin
          aluout_load = 1'b1;
          alu_src_a   = 1'b1;
          alu_src_b   = ALUB_IMM;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          mdr_load = mem_ready;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        S_R_EXEC: begin
          aluout_load = 1'b1;
          alu_src_a   = 1'b1;
          alu_op      = ALU_FUNCT;
        end
        S_R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_BEQ: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_SUB;
          pc_src     = PC_SRC_ALUOUT;
          pc_load    = zero;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_load    = 1'b1;
          pc_src     = PC_SRC_JUMP;
          instr_done = 1'b1;
        end
        S_ADDI_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with hand-written expected control vectors.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pc_load;
    logic [1:0] pc_src;
    logic       ir_load;
    logic       mdr_load;
    logic       ab_load;
    logic       aluout_load;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_load, ir_load, mdr_load, ab_load, aluout_load, iord;
  logic       mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [6:0] state;
  logic       instr_done, illegal_op;

  ctl_t obs;
  ctl_t x_zero, x_idle, x_fetch, x_decode, x_illegal, x_maddr, x_mrd_wait, x_mrd, x_mwb;
  ctl_t x_mwr_wait, x_mwr, x_rexec, x_rwb, x_beq_t, x_beq_f, x_jump, x_awb;

  int vectors    = 0;
  int miscompares = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_load(pc_load), .pc_src(pc_src), .ir_load(ir_load), .mdr_load(mdr_load),
    .ab_load(ab_load), .aluout_load(aluout_load), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .state(state), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  always_comb begin
    obs = '{pc_load, pc_src, ir_load, mdr_load, ab_load, aluout_load, iord, mem_read,
            mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
            instr_done, illegal_op};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected control vectors for each state, written out from the state table
  task automatic init_expect;
    x_zero = '0;
    x_idle = '0;     x_idle.mem_read = 1'b1; x_idle.alu_src_b = 2'd1;
    x_fetch = x_idle; x_fetch.ir_load = 1'b1; x_fetch.pc_load = 1'b1;
    x_decode = '0;   x_decode.ab_load = 1'b1; x_decode.aluout_load = 1'b1; x_decode.alu_src_b = 2'd3;
    x_illegal = x_decode; x_illegal.illegal_op = 1'b1;
    x_maddr = '0;    x_maddr.aluout_load = 1'b1; x_maddr.alu_src_a = 1'b1; x_maddr.alu_src_b = 2'd2;
    x_mrd_wait = '0; x_mrd_wait.mem_read = 1'b1; x_mrd_wait.iord = 1'b1;
    x_mrd = x_mrd_wait; x_mrd.mdr_load = 1'b1;
    x_mwb = '0;      x_mwb.reg_write = 1'b1; x_mwb.mem_to_reg = 1'b1; x_mwb.instr_done = 1'b1;
    x_mwr_wait = '0; x_mwr_wait.mem_write = 1'b1; x_mwr_wait.iord = 1'b1;
    x_mwr = x_mwr_wait; x_mwr.instr_done = 1'b1;
    x_rexec = '0;    x_rexec.aluout_load = 1'b1; x_rexec.alu_src_a = 1'b1; x_rexec.alu_op = 2'd2;
    x_rwb = '0;      x_rwb.reg_write = 1'b1; x_rwb.reg_dst = 1'b1; x_rwb.instr_done = 1'b1;
    x_beq_f = '0;    x_beq_f.alu_src_a = 1'b1; x_beq_f.alu_op = 2'd1; x_beq_f.pc_src = 2'd1; x_beq_f.instr_done = 1'b1;
    x_beq_t = x_beq_f; x_beq_t.pc_load = 1'b1;
    x_jump = '0;     x_jump.pc_load = 1'b1; x_jump.pc_src = 2'd2; x_jump.instr_done = 1'b1;
    x_awb = '0;      x_awb.reg_write = 1'b1; x_awb.instr_done = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0; opcode = 6'h23; zero = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      if ({state, obs} !== {7'd0, x_zero}) begin miscompares++; $display("FAIL reset_hold%0d: got state=%0d ctl=%h want state=0 ctl=%h", i, state, obs, x_zero); end
      vectors++;
    end
    reset = 1'b1; mem_ready = 1'b0; #1;
    if ({state, obs} !== {7'd0, x_idle}) begin miscompares++; $display("FAIL reset_release: got state=%0d ctl=%h want state=0 ctl=%h", state, obs, x_idle); end
    vectors++;
  endtask

  task automatic test_lw;
    opcode = 6'h23; mem_ready = 1'b1; #1;
    if ({state, obs} !== {7'd0, x_fetch}) begin miscompares++; $display("FAIL lw_fetch: got state=%0d ctl=%h want state=0 ctl=%h", state, obs, x_fetch); end
    vectors++; tick;
    if ({state, obs} !== {7'd1, x_decode}) begin miscompares++; $display("FAIL lw_decode: got state=%0d ctl=%h want state=1 ctl=%h", state, obs, x_decode); end
    vectors++; tick;
    if ({state, obs} !== {7'd2, x_maddr}) begin miscompares++; $display("FAIL lw_addr: got state=%0d ctl=%h want state=2 ctl=%h", state, obs, x_maddr); end
    vectors++; tick;
    if ({state, obs} !== {7'd3, x_mrd}) begin miscompares++; $display("FAIL lw_rd: got state=%0d ctl=%h want state=3 ctl=%h", state, obs, x_mrd); end
    vectors++; tick;
    if ({state, obs} !== {7'd4, x_mwb}) begin miscompares++; $display("FAIL lw_wb: got state=%0d ctl=%h want state=4 ctl=%h", state, obs, x_mwb); end
    vectors++; tick;
    mem_ready = 1'b0; #1;
    if ({state, obs} !== {7'd0, x_idle}) begin miscompares++; $display("FAIL lw_end: got state=%0d ctl=%h want state=0 ctl=%h", state, obs, x_idle); end
    vectors++;
  endtask

  task automatic test_sw_wait;
    opcode = 6'h2B; mem_ready = 1'b1; #1;
    if ({state, obs} !== {7'd0, x_fetch}) begin miscompares++; $display("FAIL sw_fetch: got state=%0d ctl=%h want state=0 ctl=%h", state, obs, x_fetch); end
    vectors++; tick;
    if ({state, obs} !== {7'd1, x_decode}) begin miscompares++; $display("FAIL sw_decode: got state=%0d ctl=%h want state=1 ctl=%h", state, obs, x_decode); end
    vectors++; tick;
    if ({state, obs} !== {7'd2, x_maddr}) begin miscompares++; $display("FAIL sw_addr: got state=%0d ctl=%h want state=2 ctl=%h", state, obs, x_maddr); end
    vectors++; tick;
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      if ({state, obs} !== {7'd5, x_mwr_wait}) begin miscompares++; $display("FAIL sw_wait%0d: got state=%0d ctl=%h want state=5 ctl=%h", i, state, obs, x_mwr_wait); end
      vectors++; tick;
    end
    mem_ready = 1'b1; #1;
    if ({state, obs} !== {7'd5, x_mwr}) begin miscompares++; $display("FAIL sw_done: got state=%0d ctl=%h want state=5 ctl=%h", state, obs, x_mwr); end
    vectors++; tick;
    mem_ready = 1'b0; #1;
    if ({state, obs} !== {7'd0, x_idle}) begin miscompares++; $display("FAIL sw_end: got state=%0d ctl=%h want state=0 ctl=%h", state, obs, x_idle); end
    vectors++;
  endtask

  task automatic test_beq;
    for (int z = 1; z >= 0; z--) begin
      opcode = 6'h04; mem_ready = 1'b1; zero = 1'b0; #1;
      if ({state, obs} !== {7'd0, x_fetch}) begin miscompares++; $display("FAIL beq%0d_fetch: got state=%0d ctl=%h want state=0 ctl=%h", z, state, obs, x_fetch); end
      vectors++; tick;
      tick;
      zero = 1'(z); #1;
      if (z == 1) begin
        if ({state, obs} !== {7'd8, x_beq_t}) begin miscompares++; $display("FAIL beq_taken: got state=%0d ctl=%h want state=8 ctl=%h", state, obs, x_beq_t); end
      end else begin
        if ({state, obs} !== {7'd8, x_beq_f}) begin miscompares++; $display("FAIL beq_not_taken: got state=%0d ctl=%h want state=8 ctl=%h", state, obs, x_beq_f); end
      end
      vectors++; tick;
      mem_ready = 1'b0; #1;
      if ({state, obs} !== {7'd0, x_idle}) begin miscompares++; $display("FAIL beq%0d_end: got state=%0d ctl=%h want state=0 ctl=%h", z, state, obs, x_idle); end
      vectors++;
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal;
    opcode = 6'h3F; mem_ready = 1'b1; #1;
    tick;
    if ({state, obs} !== {7'd1, x_illegal}) begin miscompares++; $display("FAIL illegal_decode: got state=%0d ctl=%h want state=1 ctl=%h", state, obs, x_illegal); end
    vectors++; tick;
    mem_ready = 1'b0; #1;
    if ({state, obs} !== {7'd0, x_idle}) begin miscompares++; $display("FAIL illegal_end: got state=%0d ctl=%h want state=0 ctl=%h", state, obs, x_idle); end
    vectors++;
  endtask

  task automatic test_reset_mid;
    opcode = 6'h00; mem_ready = 1'b1; #1;
    tick; tick;
    if ({state, obs} !== {7'd6, x_rexec}) begin miscompares++; $display("FAIL r_exec: got state=%0d ctl=%h want state=6 ctl=%h", state, obs, x_rexec); end
    vectors++; tick;
    if ({state, obs} !== {7'd7, x_rwb}) begin miscompares++; $display("FAIL r_wb: got state=%0d ctl=%h want state=7 ctl=%h", state, obs, x_rwb); end
    vectors++;
    reset = 1'b0; #1;
    if ({state, obs} !== {7'd0, x_zero}) begin miscompares++; $display("FAIL rst_in_rwb: got state=%0d ctl=%h want state=0 ctl=%h", state, obs, x_zero); end
    vectors++; tick;
    reset = 1'b1; opcode = 6'h23; mem_ready = 1'b1; #1;
    tick; tick; tick;
    mem_ready = 1'b0; #1;
    if ({state, obs} !== {7'd3, x_mrd_wait}) begin miscompares++; $display("FAIL lw_rd_wait: got state=%0d ctl=%h want state=3 ctl=%h", state, obs, x_mrd_wait); end
    vectors++;
    reset = 1'b0; #1;
    if ({state, obs} !== {7'd0, x_zero}) begin miscompares++; $display("FAIL rst_in_rd: got state=%0d ctl=%h want state=0 ctl=%h", state, obs, x_zero); end
    vectors++; tick;
    reset = 1'b1; #1;
    if ({state, obs} !== {7'd0, x_idle}) begin miscompares++; $display("FAIL rst_in_rd_after: got state=%0d ctl=%h want state=0 ctl=%h", state, obs, x_idle); end
    vectors++;
  endtask

  task automatic test_fetch_wait;
    opcode = 6'h08; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if ({state, obs} !== {7'd0, x_idle}) begin miscompares++; $display("FAIL fetch_wait%0d: got state=%0d ctl=%h want state=0 ctl=%h", i, state, obs, x_idle); end
      vectors++; tick;
    end
    mem_ready = 1'b1; #1;
    if ({state, obs} !== {7'd0, x_fetch}) begin miscompares++; $display("FAIL fetch_go: got state=%0d ctl=%h want state=0 ctl=%h", state, obs, x_fetch); end
    vectors++; tick;
    if ({state, obs} !== {7'd1, x_decode}) begin miscompares++; $display("FAIL addi_decode: got state=%0d ctl=%h want state=1 ctl=%h", state, obs, x_decode); end
    vectors++; tick;
    if ({state, obs} !== {7'd10, x_maddr}) begin miscompares++; $display("FAIL addi_exec: got state=%0d ctl=%h want state=10 ctl=%h", state, obs, x_maddr); end
    vectors++; tick;
    if ({state, obs} !== {7'd11, x_awb}) begin miscompares++; $display("FAIL addi_wb: got state=%0d ctl=%h want state=11 ctl=%h", state, obs, x_awb); end
    vectors++; tick;
    mem_ready = 1'b0; #1;
    if ({state, obs} !== {7'd0, x_idle}) begin miscompares++; $display("FAIL addi_end: got state=%0d ctl=%h want state=0 ctl=%h", state, obs, x_idle); end
    vectors++;
  endtask

  task automatic test_back_to_back;
    opcode = 6'h02; mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      if ({state, obs} !== {7'd0, x_fetch}) begin miscompares++; $display("FAIL j%0d_fetch: got state=%0d ctl=%h want state=0 ctl=%h", i, state, obs, x_fetch); end
      vectors++; tick;
      if ({state, obs} !== {7'd1, x_decode}) begin miscompares++; $display("FAIL j%0d_decode: got state=%0d ctl=%h want state=1 ctl=%h", i, state, obs, x_decode); end
      vectors++; tick;
      if ({state, obs} !== {7'd9, x_jump}) begin miscompares++; $display("FAIL j%0d_jump: got state=%0d ctl=%h want state=9 ctl=%h", i, state, obs, x_jump); end
      vectors++; tick;
    end
    mem_ready = 1'b0; #1;
    if ({state, obs} !== {7'd0, x_idle}) begin miscompares++; $display("FAIL j_end: got state=%0d ctl=%h want state=0 ctl=%h", state, obs, x_idle); end
    vectors++;
  endtask

  initial begin
    init_expect;
    test_reset;
    test_lw;
    test_sw_wait;
    test_beq;
    test_illegal;
    test_reset_mid;
    test_fetch_wait;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
